// File: rtl/mips_pkg.sv
// Shared MEM-stage definitions: responder FSM encodings, word width and
// default geometry/latency for the data-memory responder.
package mips_pkg;

  localparam int WORD_W        = 32;
  localparam int DEF_ADDR_BITS = 10;
  localparam int DEF_LATENCY   = 2;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/data_mem_resp_if.sv
// MEM-stage request/response bundle between the EX/MEM register side
// (master) and the data-memory responder (slave).
interface data_mem_resp_if;
  import mips_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [31:0]       addr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              stall_mem;
  logic              misalign;
  logic              busy;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, stall_mem, misalign, busy
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, stall_mem, misalign, busy
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous data RAM with write strobe and registered read port.
// The read register can be cleared to return zero for rejected loads.
module dmem_array
  import mips_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic                 re,
  input  logic                 clr,
  input  logic [ADDR_BITS-1:0] idx,
  input  logic [WORD_W-1:0]    wdata,
  output logic [WORD_W-1:0]    q
);

  logic [WORD_W-1:0] mem [2**ADDR_BITS];

  // NOTE: the storage array has no reset; only the read register is cleared,
  // so the array maps onto plain RAM macros.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset)    q <= '0;
    else if (clr) q <= '0;
    else if (re)  q <= mem[idx];
  end

endmodule

// File: rtl/data_mem_resp.sv
// MEM-stage data-memory responder: services a load/store over a fixed latency,
// stalling the pipeline until the DONE cycle.
module data_mem_resp
  import mips_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int LATENCY   = DEF_LATENCY
) (
  input  logic          clk,
  input  logic          reset,
  data_mem_resp_if.slave bus
);

  mem_state_t state, state_next;
  logic [3:0] cnt, cnt_next;

  logic                 req;
  logic                 is_read;
  logic                 aligned;
  logic                 enter_done;
  logic                 ram_we, ram_re, ram_clr;
  logic [ADDR_BITS-1:0] idx;

  assign req     = bus.mem_read | bus.mem_write;
  assign is_read = bus.mem_read & ~bus.mem_write;
  assign aligned = (bus.addr[1:0] == 2'b00);
  assign idx     = bus.addr[ADDR_BITS+1:2];

  // High address bits are deliberately dropped: addresses wrap modulo depth.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:ADDR_BITS+2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MEM_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // cnt counts remaining WAIT cycles; leaving at cnt==1 gives LATENCY-1 WAIT
  // cycles, so an access spans LATENCY+1 cycles with LATENCY of them stalled.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      MEM_IDLE: begin
        if (req) begin
          cnt_next   = 4'(LATENCY - 1);
          state_next = (LATENCY == 1) ? MEM_DONE : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (cnt <= 4'd1) begin
          cnt_next   = 4'd0;
          state_next = MEM_DONE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      MEM_DONE: state_next = MEM_IDLE;
      default:  state_next = MEM_IDLE;
    endcase
  end

  always_comb begin
    enter_done    = (state != MEM_DONE) && (state_next == MEM_DONE);
    bus.stall_mem = ((state == MEM_IDLE) && req) || (state == MEM_WAIT);
    bus.busy      = (state != MEM_IDLE);
    bus.misalign  = req && !aligned;
    // Load data is captured on entry to DONE so it is valid for the whole cycle.
    ram_re        = enter_done && is_read && aligned;
    ram_clr       = enter_done && is_read && !aligned;
    // Stores commit on the edge leaving DONE; a reset on that edge cancels it.
    ram_we        = (state == MEM_DONE) && bus.mem_write && aligned && !reset;
  end

  dmem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .re    (ram_re),
    .clr   (ram_clr),
    .idx   (idx),
    .wdata (bus.wdata),
    .q     (bus.rdata)
  );

endmodule
